// File: rtl/bn_factor_encoder.sv
// bn_factor_encoder: sequential search over the legal shift-add scale table.
// Scans one candidate per cycle and keeps the one nearest the requested scale.
// The x8 code is only legal when the addend is zero.
// Results are registered and pulse `done` in the same cycle they update.
module bn_factor_encoder #(
  parameter int WIDTH        = 6,
  parameter int ADDEND_WIDTH = WIDTH - 2,
  parameter int SCALE_WIDTH  = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic        [SCALE_WIDTH-1:0]  target_scale,
  input  logic signed [ADDEND_WIDTH-1:0] target_addend,
  output logic                           busy,
  output logic                           done,
  output logic        [3:0]              BN_factor,
  output logic signed [ADDEND_WIDTH-1:0] BN_addend,
  output logic                           exact,
  output logic        [SCALE_WIDTH-1:0]  err
);

  localparam int SW1 = SCALE_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

  state_t                        state_q;
  logic [3:0]                    idx_q;
  logic [SCALE_WIDTH-1:0]        tgt_q;
  logic signed [ADDEND_WIDTH-1:0] add_q;
  logic [SW1-1:0]                best_err_q;
  logic [3:0]                    best_code_q;

  logic [SW1-1:0] cand_scale;
  logic [3:0]     cand_code;
  logic [SW1-1:0] tgt_ext;
  logic [SW1-1:0] diff;
  logic           skip;

  // Candidate table, ascending scale order (quarter units -> shift code)
  always_comb begin
    cand_scale = SW1'(4);
    cand_code  = 4'b0100;
    case (idx_q)
      4'd0:  begin cand_scale = SW1'(1);  cand_code = 4'b1000; end
      4'd1:  begin cand_scale = SW1'(2);  cand_code = 4'b0001; end
      4'd2:  begin cand_scale = SW1'(3);  cand_code = 4'b1001; end
      4'd3:  begin cand_scale = SW1'(4);  cand_code = 4'b0100; end
      4'd4:  begin cand_scale = SW1'(6);  cand_code = 4'b0101; end
      4'd5:  begin cand_scale = SW1'(8);  cand_code = 4'b0010; end
      4'd6:  begin cand_scale = SW1'(9);  cand_code = 4'b1010; end
      4'd7:  begin cand_scale = SW1'(12); cand_code = 4'b0110; end
      4'd8:  begin cand_scale = SW1'(16); cand_code = 4'b1100; end
      4'd9:  begin cand_scale = SW1'(18); cand_code = 4'b1101; end
      4'd10: begin cand_scale = SW1'(24); cand_code = 4'b1110; end
      4'd11: begin cand_scale = SW1'(32); cand_code = 4'b0011; end
      default: ;
    endcase
  end

  // Distance to the target; x8 is off-limits whenever the addend is non-zero
  always_comb begin
    tgt_ext = {1'b0, tgt_q};
    diff    = (tgt_ext >= cand_scale) ? (tgt_ext - cand_scale) : (cand_scale - tgt_ext);
    skip    = (cand_code == 4'b0011) && (add_q != '0);
  end

  // Search FSM with registered outputs; outputs only move in DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      tgt_q       <= '0;
      add_q       <= '0;
      best_err_q  <= '1;
      best_code_q <= 4'b0100;
      busy        <= 1'b0;
      done        <= 1'b0;
      BN_factor   <= 4'b0100;
      BN_addend   <= '0;
      exact       <= 1'b1;
      err         <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            tgt_q       <= target_scale;
            add_q       <= target_addend;
            idx_q       <= '0;
            best_err_q  <= '1;
            best_code_q <= 4'b0100;
            busy        <= 1'b1;
            state_q     <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          // Strict less-than keeps the smaller scale on ties
          if (!skip && (diff < best_err_q)) begin
            best_err_q  <= diff;
            best_code_q <= cand_code;
          end
          idx_q <= idx_q + 4'd1;
          if (idx_q == 4'd11) state_q <= S_DONE;
        end
        S_DONE: begin
          BN_factor <= best_code_q;
          BN_addend <= add_q;
          err       <= best_err_q[SCALE_WIDTH-1:0];
          exact     <= (best_err_q == '0);
          done      <= 1'b1;
          busy      <= 1'b0;
          idx_q     <= '0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bn_factor_encoder.sv
// Bench for bn_factor_encoder: directed requests, a table-level reference model,
// per-cycle comparison of every output, plus literal pins on model and DUT.
module tb_bn_factor_encoder;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [5:0]        target_scale;
  logic signed [3:0] target_addend;
  logic              busy, done, exact;
  logic [3:0]        BN_factor;
  logic signed [3:0] BN_addend;
  logic [5:0]        err;

  bn_factor_encoder #(.WIDTH(6), .SCALE_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .target_scale(target_scale), .target_addend(target_addend),
    .busy(busy), .done(done), .BN_factor(BN_factor), .BN_addend(BN_addend),
    .exact(exact), .err(err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  logic              exp_busy, exp_done, exp_exact;
  logic [3:0]        exp_f;
  logic signed [3:0] exp_add;
  logic [5:0]        exp_err;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: nearest legal scale, smallest scale on a tie
  function automatic void model(input int ts, input int ad, output logic [3:0] f, output int e);
    int sc[12] = '{1, 2, 3, 4, 6, 8, 9, 12, 16, 18, 24, 32};
    logic [3:0] cd[12] = '{4'b1000, 4'b0001, 4'b1001, 4'b0100, 4'b0101, 4'b0010,
                           4'b1010, 4'b0110, 4'b1100, 4'b1101, 4'b1110, 4'b0011};
    int best = 1000;
    int d;
    f = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      if (sc[i] == 32 && ad != 0) continue;
      d = (ts > sc[i]) ? ts - sc[i] : sc[i] - ts;
      if (d < best) best = d;
    end
    for (int i = 11; i >= 0; i--) begin
      if (sc[i] == 32 && ad != 0) continue;
      d = (ts > sc[i]) ? ts - sc[i] : sc[i] - ts;
      if (d == best) f = cd[i];
    end
    e = best;
  endfunction

  task automatic check_all();
    if (chk_en) begin
      cmp("busy", 32'(busy), 32'(exp_busy));
      cmp("done", 32'(done), 32'(exp_done));
      cmp("BN_factor", 32'(BN_factor), 32'(exp_f));
      cmp("BN_addend", 32'(BN_addend), 32'(exp_add));
      cmp("exact", 32'(exact), 32'(exp_exact));
      cmp("err", 32'(err), 32'(exp_err));
    end
  endtask

  // Check current outputs mid-cycle, then advance one rising edge
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reset_exp();
    exp_busy = 0; exp_done = 0; exp_f = 4'b0100; exp_add = '0; exp_exact = 1; exp_err = '0;
  endtask

  // One request; inj = edge index of an extra ignored start, rst_at = edge of a mid-search reset
  task automatic run_req(input int ts, input int ad, input int inj, input int rst_at);
    logic [3:0] f;
    int e;
    target_scale = 6'(ts);
    target_addend = 4'(ad);
    start = 1;
    tick();
    start = 0;
    exp_busy = 1; exp_done = 0;
    for (int i = 1; i <= 13; i++) begin
      start = (i == inj);
      if (i == inj) target_scale = 6'd32;
      if (i == rst_at) rst_n = 0;
      tick();
      start = 0;
      if (i == rst_at) begin
        set_reset_exp();
        return;
      end
      if (i == 13) begin
        model(ts, ad, f, e);
        exp_busy = 0; exp_done = 1; exp_f = f; exp_add = 4'(ad);
        exp_err = 6'(e); exp_exact = (e == 0);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      exp_done = 0; exp_busy = 0;
    end
  endtask

  initial begin
    logic [3:0] mf;
    int me;
    rst_n = 0; start = 0; target_scale = '0; target_addend = '0;
    set_reset_exp();
    tick();
    chk_en = 1;
    tick();
    rst_n = 1;
    idle(1);
    cmp("rst_factor", 32'(BN_factor), 32'h4);
    cmp("rst_exact", 32'(exact), 32'h1);
    cmp("rst_busy", 32'(busy), 32'h0);

    // Model pins
    model(7, 0, mf, me);   cmp("model_tie", 32'(mf), 32'b0101);   cmp("model_tie_err", me, 1);
    model(40, 3, mf, me);  cmp("model_x8", 32'(mf), 32'b1110);    cmp("model_x8_err", me, 16);
    model(40, 0, mf, me);  cmp("model_x8ok", 32'(mf), 32'b0011);  cmp("model_x8ok_err", me, 8);
    model(0, 0, mf, me);   cmp("model_zero", 32'(mf), 32'b1000);  cmp("model_zero_err", me, 1);

    // Exact match, negative addend; literal pins read in the done cycle
    run_req(9, -2, 0, 0);
    cmp("lit9_done", 32'(done), 32'h1);
    cmp("lit9_factor", 32'(BN_factor), 32'b1010);
    cmp("lit9_addend", 32'(BN_addend), 32'(4'(-2)));
    cmp("lit9_exact", 32'(exact), 32'h1);
    cmp("lit9_err", 32'(err), 32'h0);

    // Back-to-back: next start is sampled at the edge ending the done cycle
    run_req(7, 0, 0, 0);
    cmp("lit7_factor", 32'(BN_factor), 32'b0101);
    cmp("lit7_err", 32'(err), 32'h1);
    run_req(0, 0, 0, 0);
    cmp("lit0_factor", 32'(BN_factor), 32'b1000);
    cmp("lit0_exact", 32'(exact), 32'h0);
    run_req(40, 0, 0, 0);
    cmp("lit40a0_factor", 32'(BN_factor), 32'b0011);
    cmp("lit40a0_err", 32'(err), 32'h8);
    run_req(40, 3, 0, 0);
    cmp("lit40a3_factor", 32'(BN_factor), 32'b1110);
    cmp("lit40a3_err", 32'(err), 32'd16);
    cmp("lit40a3_exact", 32'(exact), 32'h0);
    idle(2);

    // Start while busy is dropped; no second search follows
    run_req(4, 0, 5, 0);
    cmp("litbusy_factor", 32'(BN_factor), 32'b0100);
    idle(16);

    run_req(32, 0, 0, 0);
    run_req(32, 1, 0, 0);
    run_req(63, -8, 0, 0);
    run_req(1, 7, 0, 0);
    idle(2);

    // Reset mid-search aborts quietly, then a fresh request completes
    run_req(18, 2, 0, 6);
    idle(1);
    rst_n = 1;
    idle(3);
    run_req(12, 5, 0, 0);
    cmp("lit12_factor", 32'(BN_factor), 32'b0110);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
